wdma2_burst_ctrl: RTL and testbench

Write-side burst controller for HP port 2. It slices the output feature map stream into fixed-length AXI write bursts and drives AW valid/length, W valid/last and B ready. It sequences the bursts for one layer and pulses a done flag when the layer completes. It sits between the PE output buffer, which is the source of the write beats, and the AXI HP2 write channels; the address comes from a separate address generator.

---
 rtl/wdma2_pkg.sv | 31 +++
 rtl/wdma2_total_calc.sv | 51 +++++
 rtl/wdma2_burst_ctrl.sv | 155 +++++++++++++++
 tb/tb_wdma2_burst_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdma2_pkg.sv
// Shared state encoding, burst beat counts and width-tile lookup for the HP2 write burst controller.
package wdma2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    AW,
    WDATA,
    WRESP,
    DONE
  } wdma2_state_e;

  localparam int unsigned BEATS_CONV = 4;
  localparam int unsigned BEATS_MP   = 13;
  localparam logic [3:0]  LEN_CONV   = 4'(BEATS_CONV - 1);
  localparam logic [3:0]  LEN_MP     = 4'(BEATS_MP - 1);

  // Number of 13-pixel tiles across a supported output width; unsupported widths give 0.
  function automatic logic [5:0] w_tiles(input logic [8:0] width);
    case (width)
      9'd416:  w_tiles = 6'd32;
      9'd208:  w_tiles = 6'd16;
      9'd104:  w_tiles = 6'd8;
      9'd52:   w_tiles = 6'd4;
      9'd26:   w_tiles = 6'd2;
      9'd13:   w_tiles = 6'd1;
      default: w_tiles = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/wdma2_total_calc.sv
// Two-stage registered burst-count product: width x tiles, then x channel groups.
module wdma2_total_calc
  import wdma2_pkg::*;
#(
  parameter int unsigned BURST_W = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [8:0]         width_i,
  input  logic [6:0]         ch_grp_i,
  output logic [BURST_W-1:0] total_o,
  output logic               valid_o
);

  localparam int unsigned PW = (BURST_W > 22) ? BURST_W : 22;

  logic [14:0]        wt_q, wt_d;
  logic [6:0]         grp_q;
  logic               s1_vld_q;
  logic               valid_q;
  logic [BURST_W-1:0] total_q;
  logic [PW-1:0]      prod_d;

  assign wt_d   = 15'(width_i) * 15'(w_tiles(width_i));
  assign prod_d = PW'(wt_q) * PW'(grp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      wt_q     <= '0;
      grp_q    <= '0;
      s1_vld_q <= 1'b0;
      valid_q  <= 1'b0;
      total_q  <= '0;
    end else begin
      s1_vld_q <= load_i;
      valid_q  <= s1_vld_q;
      if (load_i) begin
        wt_q  <= wt_d;
        grp_q <= ch_grp_i;
      end
      if (s1_vld_q) begin
        total_q <= prod_d[BURST_W-1:0];
      end
    end
  end

  assign total_o = total_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/wdma2_burst_ctrl.sv
// HP2 write burst controller: slices the OFM stream into fixed-length AXI write bursts per layer.
// Optional WDMA2_BRESP_CHECK_EN adds a sticky wr_err on non-OKAY write responses.
module wdma2_burst_ctrl
  import wdma2_pkg::*;
#(
  parameter int unsigned BURST_W = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wdma2_start,
  input  logic               is_conv_1,
  input  logic               is_maxpooling,
  input  logic               is_conv_3,
  input  logic [8:0]         ofm_width,
  input  logic [10:0]        ofm_channel,
  input  logic               src_valid,
  output logic               src_ready,
  output logic               aw_valid,
  input  logic               aw_ready,
  output logic [3:0]         aw_len,
  output logic               w_valid,
  input  logic               w_ready,
  output logic               w_last,
  input  logic               b_valid,
  input  logic [1:0]         b_resp,
  output logic               b_ready,
  output logic               wdma2_done,
  output logic [BURST_W-1:0] burst_idx,
  output logic               wr_err
);

  wdma2_state_e       state_q, state_d;
  logic [3:0]         aw_len_q, aw_len_d;
  logic [3:0]         beat_cnt_q, beat_cnt_d;
  logic [BURST_W-1:0] burst_idx_q, burst_idx_d;
  logic [BURST_W-1:0] total;
  logic               total_vld;
  logic               layer_go;
  logic               unused_ch;

  assign layer_go  = (state_q == IDLE) & wdma2_start & (is_conv_1 | is_maxpooling | is_conv_3);
  assign unused_ch = ^ofm_channel[3:0];

  wdma2_total_calc #(
    .BURST_W(BURST_W)
  ) u_total_calc (
    .clk      (clk),
    .rst      (rst),
    .load_i   (layer_go),
    .width_i  (ofm_width),
    .ch_grp_i (ofm_channel[10:4]),
    .total_o  (total),
    .valid_o  (total_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      aw_len_q    <= '0;
      beat_cnt_q  <= '0;
      burst_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      aw_len_q    <= aw_len_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_idx_q <= burst_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    aw_len_d    = aw_len_q;
    beat_cnt_d  = beat_cnt_q;
    burst_idx_d = burst_idx_q;
    aw_valid    = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    src_ready   = 1'b0;
    b_ready     = 1'b0;
    wdma2_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (layer_go) begin
          state_d  = SETUP;
          aw_len_d = is_conv_1 ? LEN_CONV : (is_maxpooling ? LEN_MP : LEN_CONV);
        end
      end
      // Stay in SETUP until the product pipeline delivers its result (two cycles).
      SETUP: begin
        if (total_vld) begin
          state_d = (total == '0) ? DONE : AW;
        end
      end
      AW: begin
        aw_valid = 1'b1;
        if (aw_ready) begin
          state_d    = WDATA;
          beat_cnt_d = '0;
        end
      end
      WDATA: begin
        w_valid   = src_valid;
        src_ready = w_ready;
        w_last    = src_valid & (beat_cnt_q == aw_len_q);
        if (src_valid & w_ready) begin
          if (beat_cnt_q == aw_len_q) begin
            state_d    = WRESP;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end
      end
      WRESP: begin
        b_ready = 1'b1;
        if (b_valid) begin
          if (burst_idx_q == total - BURST_W'(1)) begin
            state_d = DONE;
          end else begin
            burst_idx_d = burst_idx_q + BURST_W'(1);
            state_d     = AW;
          end
        end
      end
      DONE: begin
        wdma2_done  = 1'b1;
        burst_idx_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign aw_len    = aw_len_q;
  assign burst_idx = burst_idx_q;

`ifdef WDMA2_BRESP_CHECK_EN
  logic wr_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else if (b_valid & b_ready & (b_resp != 2'b00)) begin
      wr_err_q <= 1'b1;
    end
  end

  assign wr_err = wr_err_q;
`else
  logic unused_resp;
  assign unused_resp = ^b_resp;
  assign wr_err      = 1'b0;
`endif

endmodule

// File: tb/tb_wdma2_burst_ctrl.sv
// Directed bench for wdma2_burst_ctrl with a transaction-level protocol model checked every cycle.
module tb_wdma2_burst_ctrl;

  localparam int unsigned BW = 21;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wdma2_start = 1'b0;
  logic          is_conv_1 = 1'b0;
  logic          is_maxpooling = 1'b0;
  logic          is_conv_3 = 1'b0;
  logic [8:0]    ofm_width = '0;
  logic [10:0]   ofm_channel = '0;
  logic          src_valid, src_ready, aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic          b_valid, b_ready, wdma2_done, wr_err;
  logic [3:0]    aw_len;
  logic [1:0]    b_resp;
  logic [BW-1:0] burst_idx;

  always #5 clk = ~clk;

  wdma2_burst_ctrl #(.BURST_W(BW)) dut (
    .clk(clk), .rst(rst), .wdma2_start(wdma2_start),
    .is_conv_1(is_conv_1), .is_maxpooling(is_maxpooling), .is_conv_3(is_conv_3),
    .ofm_width(ofm_width), .ofm_channel(ofm_channel),
    .src_valid(src_valid), .src_ready(src_ready),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready),
    .wdma2_done(wdma2_done), .burst_idx(burst_idx), .wr_err(wr_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Slave/source knobs (written by main, read by the slave process)
  bit tog = 0, gaps = 0, early_b = 0;
  int err_burst = -1;

  // Slave / upstream source behaviour
  int dcyc = 0, bseen = 0;
  bit hs_src, hs_last, hs_b, rst_s, done_s;
  initial begin : slave
    aw_ready = 0; w_ready = 0; src_valid = 0; b_valid = 0; b_resp = 0;
    forever begin
      @(negedge clk);
      hs_src = src_valid && src_ready;
      hs_last = hs_src && w_last;
      hs_b = b_valid && b_ready;
      rst_s = rst;
      done_s = wdma2_done;
      @(posedge clk); #1;
      dcyc++;
      if (rst_s) begin
        src_valid = 0; b_valid = 0; b_resp = 0; w_ready = 0; aw_ready = 0; bseen = 0;
      end else begin
        aw_ready = 1;
        w_ready = tog ? dcyc[0] : 1'b1;
        if (!(src_valid && !hs_src)) src_valid = gaps ? (dcyc % 3 != 0) : 1'b1;
        if (hs_b) begin b_valid = 0; b_resp = 0; bseen++; end
        if (!b_valid && (early_b ? hs_src : hs_last)) begin
          b_valid = 1;
          b_resp = (bseen == err_burst) ? 2'b10 : 2'b00;
        end
        if (done_s) bseen = 0;
      end
    end
  end

  function automatic int tiles(input int w);
    if (w == 13 || w == 26 || w == 52 || w == 104 || w == 208 || w == 416) return w / 13;
    return 0;
  endfunction

  // Transaction-level model state and observed counters
  int cyc = 0, m_total = 0, m_beats = 0, start_c = 0, aw_cnt = 0, beat_in = 0;
  bit active = 0, outst = 0, done_nx = 0, err_exp = 0;
  bit exp_done, exp_aw, in_data, in_resp;
  longint exp_idx;
  int obs_aw = 0, obs_beats = 0, obs_last = 0, obs_done = 0, last_aw_idx = 0;
  int last_done_c = 0, last_start_c = 0;

  initial begin : compare
    forever begin
      @(negedge clk);
      cyc++;
      exp_done = done_nx || (active && m_total == 0 && cyc == start_c + 3);
      exp_aw   = active && !outst && aw_cnt < m_total && cyc >= start_c + 3;
      in_data  = active && outst && beat_in < m_beats;
      in_resp  = active && outst && beat_in == m_beats;
      if (exp_done) exp_idx = (m_total == 0) ? 0 : m_total - 1;
      else if (active) exp_idx = (aw_cnt == 0) ? 0 : aw_cnt - (outst ? 1 : 0);
      else exp_idx = 0;
      chk("aw_valid", aw_valid, exp_aw);
      if (exp_aw) chk("aw_len", aw_len, m_beats - 1);
      chk("w_valid", w_valid, in_data ? src_valid : 1'b0);
      chk("src_ready", src_ready, in_data ? w_ready : 1'b0);
      chk("w_last", w_last, in_data && src_valid && beat_in == m_beats - 1);
      chk("b_ready", b_ready, in_resp);
      chk("wdma2_done", wdma2_done, exp_done);
      chk("burst_idx", burst_idx, exp_idx);
      chk("wr_err", wr_err, err_exp);

      if (aw_valid && aw_ready) begin obs_aw++; last_aw_idx = int'(burst_idx); end
      if (w_valid && w_ready) begin obs_beats++; if (w_last) obs_last++; end
      if (wdma2_done) begin obs_done++; last_done_c = cyc; end

      if (rst) begin
        active = 0; outst = 0; done_nx = 0; err_exp = 0; aw_cnt = 0; beat_in = 0;
      end else begin
        done_nx = 0;
        if (exp_done) active = 0;
        if (active) begin
          if (exp_aw && aw_ready) begin aw_cnt++; outst = 1; beat_in = 0; end
          if (in_data && src_valid && w_ready) beat_in++;
          if (in_resp && b_valid) begin
            outst = 0;
`ifdef WDMA2_BRESP_CHECK_EN
            if (b_resp != 2'b00) err_exp = 1;
`endif
            if (aw_cnt == m_total) done_nx = 1;
          end
        end else if (!exp_done && wdma2_start && (is_conv_1 || is_maxpooling || is_conv_3)) begin
          active = 1; start_c = cyc; last_start_c = cyc; aw_cnt = 0; beat_in = 0; outst = 0;
          m_total = (int'(ofm_width) * tiles(int'(ofm_width)) * (int'(ofm_channel) / 16)) % (1 << BW);
          m_beats = is_conv_1 ? 4 : (is_maxpooling ? 13 : 4);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_layer(input bit c1, input bit mp, input bit c3, input int w, input int ch);
    is_conv_1 = c1; is_maxpooling = mp; is_conv_3 = c3;
    ofm_width = 9'(w); ofm_channel = 11'(ch);
    wdma2_start = 1; step(1); wdma2_start = 0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0, n;
    d0 = obs_done; n = 0;
    while (obs_done == d0 && n < budget) begin step(1); n++; end
    step(2);
    chk({nm, "_done_count"}, obs_done - d0, 1);
  endtask

  int a0, bt0, l0, d0, n;
  bit exp_err_flag;

  initial begin : main
    rst = 1; step(3);
    chk("reset_ctl_outputs", {aw_valid, w_valid, w_last, src_ready, b_ready, wdma2_done, wr_err}, 0);
    chk("reset_aw_len", aw_len, 0);
    chk("reset_burst_idx", burst_idx, 0);
    rst = 0; step(2);

    // conv3, 13 x 16ch, zero-wait slave
    a0 = obs_aw; bt0 = obs_beats; l0 = obs_last;
    start_layer(0, 0, 1, 13, 16);
    wait_done("A", 3000);
    chk("A_bursts", obs_aw - a0, 13);
    chk("A_beats", obs_beats - bt0, 52);
    chk("A_wlast", obs_last - l0, 13);
    chk("A_start_to_done", last_done_c - last_start_c, 81);

    // maxpool, 13 x 32ch, with a stray start during WDATA
    a0 = obs_aw; bt0 = obs_beats; l0 = obs_last;
    start_layer(0, 1, 0, 13, 32);
    n = 0;
    while (!w_valid && n < 50) begin step(1); n++; end
    chk("B_reached_wdata", w_valid, 1);
    wdma2_start = 1; step(1); wdma2_start = 0;
    wait_done("B", 6000);
    chk("B_bursts", obs_aw - a0, 26);
    chk("B_beats", obs_beats - bt0, 338);
    chk("B_wlast", obs_last - l0, 26);
    chk("B_last_idx", last_aw_idx, 25);
    chk("B_start_to_done", last_done_c - last_start_c, 393);

    // conv1 (with conv3 also set), 26 x 16ch, w_ready toggling, src gaps, early B
    tog = 1; gaps = 1; early_b = 1;
    a0 = obs_aw; bt0 = obs_beats; l0 = obs_last;
    start_layer(1, 0, 1, 26, 16);
    wait_done("C", 8000);
    chk("C_bursts", obs_aw - a0, 52);
    chk("C_beats", obs_beats - bt0, 208);
    chk("C_wlast", obs_last - l0, 52);
    tog = 0; gaps = 0; early_b = 0;
    step(2);

    // unsupported width: immediate done, no AW
    a0 = obs_aw;
    start_layer(0, 0, 1, 100, 16);
    wait_done("D", 20);
    chk("D_bursts", obs_aw - a0, 0);
    chk("D_start_to_done", last_done_c - last_start_c, 3);

    // start with no mode flag is ignored
    a0 = obs_aw; d0 = obs_done;
    start_layer(0, 0, 0, 13, 16);
    step(10);
    chk("E_noflag_done", obs_done - d0, 0);
    chk("E_noflag_bursts", obs_aw - a0, 0);

    // error response on burst 5
    err_burst = 5;
    a0 = obs_aw;
    start_layer(0, 0, 1, 13, 16);
    wait_done("F", 3000);
    chk("F_bursts", obs_aw - a0, 13);
`ifdef WDMA2_BRESP_CHECK_EN
    exp_err_flag = 1;
`else
    exp_err_flag = 0;
`endif
    chk("F_wr_err_sticky", wr_err, exp_err_flag);
    err_burst = -1;

    // reset during beat 2 of burst 3, then a full layer
    a0 = obs_aw; bt0 = obs_beats;
    start_layer(0, 0, 1, 13, 48);
    n = 0;
    while (obs_beats - bt0 < 14 && n < 500) begin step(1); n++; end
    chk("G_reached_beat", obs_beats - bt0, 14);
    rst = 1; step(1);
    chk("G_reset_ctl_outputs", {aw_valid, w_valid, w_last, src_ready, b_ready, wdma2_done, wr_err}, 0);
    chk("G_reset_aw_len", aw_len, 0);
    chk("G_reset_burst_idx", burst_idx, 0);
    rst = 0; step(2);
    a0 = obs_aw; bt0 = obs_beats; l0 = obs_last;
    start_layer(0, 0, 1, 13, 48);
    wait_done("H", 5000);
    chk("H_bursts", obs_aw - a0, 39);
    chk("H_beats", obs_beats - bt0, 156);
    chk("H_wlast", obs_last - l0, 39);
    chk("H_start_to_done", last_done_c - last_start_c, 237);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
